// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: sequencer state, default 800x480 panel timing,
// and the helper that derives the total line/frame length from the porch/pulse/active widths.
package video_timing_pkg;

    typedef enum logic {
        WAIT_FILL = 1'b0,
        RUN       = 1'b1
    } state_t;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    function automatic int line_total(input int fp, input int pulse, input int bp, input int disp);
        return fp + pulse + bp + disp;
    endfunction

    localparam int DEF_HTOTAL = line_total(DEF_HFP, DEF_HPULSE, DEF_HBP, DEF_HDISP);
    localparam int DEF_VTOTAL = line_total(DEF_VFP, DEF_VPULSE, DEF_VBP, DEF_VDISP);

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second clk edge
// after async_rst falls. Usable in any clock domain.
module rst_sync (
    input  logic clk,
    input  logic async_rst,
    output logic sync_rst
);

    logic [1:0] sync_ff;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sync_ff <= 2'b11;
        end else begin
            sync_ff <= {sync_ff[0], 1'b0};
        end
    end

    assign sync_rst = sync_ff[1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// Pixel-domain LCD timing sequencer: sync/blank/coordinate generation, FIFO read gating
// that starts display only on a frame boundary once the FIFO is primed, and a sticky underrun flag.
module vga_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic                     pixel_clk,
    input  logic                     sys_rst,
    input  logic                     fifo_ready,
    input  logic                     fifo_empty,
    output logic                     fifo_read,
    output logic                     hs_n,
    output logic                     vs_n,
    output logic                     blank_n,
    output logic [$clog2(HDISP)-1:0] x,
    output logic [$clog2(VDISP)-1:0] y,
    output logic                     frame_start,
    output logic                     underrun
);

    localparam int HTOTAL = line_total(HFP, HPULSE, HBP, HDISP);
    localparam int VTOTAL = line_total(VFP, VPULSE, VBP, VDISP);
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT_BEG   = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT_BEG   = VW'(VFP + VPULSE + VBP);

    logic          pixel_rst;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          in_hsync;
    logic          in_vsync;
    logic          in_active;
    state_t        state;
    state_t        state_next;

    rst_sync u_rst_sync (
        .clk       (pixel_clk),
        .async_rst (sys_rst),
        .sync_rst  (pixel_rst)
    );

    assign h_last    = (hcnt == H_LAST);
    assign v_last    = (vcnt == V_LAST);
    assign in_hsync  = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
    assign in_vsync  = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
    assign in_active = (hcnt >= H_ACT_BEG) && (vcnt >= V_ACT_BEG);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_last ? '0 : hcnt + HW'(1);
            if (h_last) begin
                vcnt <= v_last ? '0 : vcnt + VW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= WAIT_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Read strobe and frame marker come straight from registered signals, so the
    // FIFO's show-ahead data lines up with the pixel they are issued for.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        fifo_read   = 1'b0;
        frame_start = 1'b0;
        case (state)
            WAIT_FILL: begin
                if (h_last && v_last && fifo_ready) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                fifo_read   = blank_n;
                frame_start = blank_n && (x == '0) && (y == '0);
            end
            default: state_next = WAIT_FILL;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_n     <= 1'b1;
            vs_n     <= 1'b1;
            blank_n  <= 1'b0;
            x        <= '0;
            y        <= '0;
            underrun <= 1'b0;
        end else begin
            hs_n    <= !in_hsync;
            vs_n    <= !in_vsync;
            blank_n <= (state == RUN) && in_active;
            x       <= in_active ? XW'(hcnt - H_ACT_BEG) : '0;
            y       <= in_active ? YW'(vcnt - V_ACT_BEG) : '0;
            if (fifo_read && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
